// File: rtl/oc8051_int_sched_pkg.sv
// Shared types and constants for the 8051 interrupt scheduler.
package oc8051_int_sched_pkg;

  typedef enum logic [1:0] {
    OC8051_IS_IDLE = 2'd0,
    OC8051_IS_REQ  = 2'd1,
    OC8051_IS_WACK = 2'd2
  } is_state_e;

  localparam logic [2:0] OC8051_SRC_EXT0   = 3'd0;
  localparam logic [2:0] OC8051_SRC_TIMER0 = 3'd1;
  localparam logic [2:0] OC8051_SRC_EXT1   = 3'd2;
  localparam logic [2:0] OC8051_SRC_TIMER1 = 3'd3;
  localparam logic [2:0] OC8051_SRC_SERIAL = 3'd4;

  localparam logic [7:0] OC8051_VEC_BASE = 8'h03;
  localparam logic [7:0] OC8051_VEC_STEP = 8'h08;

  typedef struct packed {
    logic [2:0] idx;
    logic       lvl;
  } int_win_t;

  function automatic logic [7:0] int_vec(input logic [2:0] idx,
                                         input logic [7:0] base,
                                         input logic [7:0] step);
    return base + step * {5'd0, idx};
  endfunction

  function automatic logic [4:0] src_onehot(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

  // Fixed order: index 0 has the highest precedence within a level.
  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/oc8051_int_sched_if.sv
// Core-side bus of the interrupt scheduler: source flags, SFRs, decoder strobes and LCALL injection.
interface oc8051_int_sched_if;
  logic [4:0] src_req;
  logic [7:0] ie;
  logic [4:0] ip;
  logic       rd;
  logic       reti;
  logic       ack;
  logic       intr;
  logic [7:0] int_v;
  logic [4:0] src_clr;
  logic [1:0] in_srv;
  logic       ack_err;

  modport master (
    output src_req, ie, ip, rd, reti, ack,
    input  intr, int_v, src_clr, in_srv, ack_err
  );

  modport slave (
    input  src_req, ie, ip, rd, reti, ack,
    output intr, int_v, src_clr, in_srv, ack_err
  );
endinterface

// File: rtl/oc8051_int_sched_prio_enc.sv
// Priority encoder: picks the winning qualified source and whether it may preempt.
// Latency: combinational. Backpressure: none, valid is gated by the in-service state.
// Level: 1 = high priority; a high winner needs no high ISR active, a low one needs no ISR at all.
module oc8051_int_prio_enc
  import oc8051_int_sched_pkg::*;
(
  input  logic [4:0] cand,
  input  logic [4:0] ip,
  input  logic [1:0] in_srv,
  output logic       valid,
  output logic [2:0] index,
  output logic       level
);

  logic [4:0] hi_cand;
  logic [4:0] lo_cand;

  assign hi_cand = cand & ip;
  assign lo_cand = cand & ~ip;

  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    level = 1'b0;
    if (|hi_cand) begin
      index = lowest_idx(hi_cand);
      level = 1'b1;
      valid = ~in_srv[1];
    end else if (|lo_cand) begin
      index = lowest_idx(lo_cand);
      level = 1'b0;
      valid = (in_srv == 2'b00);
    end
  end

endmodule

// File: rtl/oc8051_int_sched.sv
// Interrupt scheduler: vectors the winning source at an instruction boundary, tracks in-service levels.
// Latency: rd sampled -> intr one cycle later; ack -> src_clr one cycle later.
// Backpressure: waits up to ACK_TIMEOUT cycles for ack, then aborts with ack_err.
module oc8051_int_sched
  import oc8051_int_sched_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [7:0]  VEC_BASE    = OC8051_VEC_BASE,
  parameter logic [7:0]  VEC_STEP    = OC8051_VEC_STEP
) (
  input logic               clk,
  input logic               rst,
  oc8051_int_sched_if.slave bus
);

  localparam logic [3:0] TMO_LOAD = 4'(ACK_TIMEOUT);

  is_state_e  state_q;
  int_win_t   win_q;
  logic [3:0] tmo_q;
  logic       intr_q;
  logic [7:0] int_v_q;
  logic [4:0] src_clr_q;
  logic [1:0] in_srv_q;
  logic [1:0] in_srv_nxt;
  logic       ack_err_q;

  logic [4:0] cand;
  logic       win_vld;
  logic [2:0] win_idx;
  logic       win_lvl;

  assign cand = bus.src_req & bus.ie[4:0] & {5{bus.ie[7]}};

  oc8051_int_prio_enc u_prio_enc (
    .cand   (cand),
    .ip     (bus.ip),
    .in_srv (in_srv_q),
    .valid  (win_vld),
    .index  (win_idx),
    .level  (win_lvl)
  );

  // RETI retires the innermost level before an ack in the same cycle sets its level.
  always_comb begin
    in_srv_nxt = in_srv_q;
    if (bus.reti) begin
      if (in_srv_nxt[1]) in_srv_nxt[1] = 1'b0;
      else               in_srv_nxt[0] = 1'b0;
    end
    if (state_q == OC8051_IS_WACK && bus.ack) begin
      if (win_q.lvl) in_srv_nxt[1] = 1'b1;
      else           in_srv_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OC8051_IS_IDLE;
      win_q     <= '0;
      tmo_q     <= 4'd0;
      intr_q    <= 1'b0;
      int_v_q   <= 8'h00;
      src_clr_q <= 5'd0;
      in_srv_q  <= 2'b00;
      ack_err_q <= 1'b0;
    end else begin
      intr_q    <= 1'b0;
      src_clr_q <= 5'd0;
      ack_err_q <= 1'b0;
      in_srv_q  <= in_srv_nxt;
      case (state_q)
        OC8051_IS_IDLE: begin
          // Hold off during the clear pulse so a flag still high this cycle is not re-taken.
          if (win_vld && bus.rd && src_clr_q == 5'd0) begin
            state_q   <= OC8051_IS_REQ;
            intr_q    <= 1'b1;
            int_v_q   <= int_vec(win_idx, VEC_BASE, VEC_STEP);
            win_q.idx <= win_idx;
            win_q.lvl <= win_lvl;
          end
        end
        OC8051_IS_REQ: begin
          tmo_q   <= TMO_LOAD;
          state_q <= OC8051_IS_WACK;
        end
        OC8051_IS_WACK: begin
          if (bus.ack) begin
            src_clr_q <= src_onehot(win_q.idx);
            state_q   <= OC8051_IS_IDLE;
          end else if (tmo_q <= 4'd1) begin
            tmo_q     <= 4'd0;
            ack_err_q <= 1'b1;
            state_q   <= OC8051_IS_IDLE;
          end else begin
            tmo_q <= tmo_q - 4'd1;
          end
        end
        default: state_q <= OC8051_IS_IDLE;
      endcase
    end
  end

  assign bus.intr    = intr_q;
  assign bus.int_v   = int_v_q;
  assign bus.src_clr = src_clr_q;
  assign bus.in_srv  = in_srv_q;
  assign bus.ack_err = ack_err_q;

endmodule
